// File: rtl/drsstc_link_tx_mch.sv
// Serial link transmitter for the DRSSTC fibre/LVDS link. Sends framed channel snapshots
// (sync, mode, data, parity, gap) and enters a fault-hold state while the SFP reports a fault.
module drsstc_link_tx_mch #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned IDLE_GAP = 2,
  parameter int unsigned FLT_CLR  = 16
) (
  input  logic            i_clk,
  input  logic            i_res_n,
  input  logic            i_en,
  input  logic            i_IsMaster,
  input  logic [N_CH-1:0] i_ch,
  input  logic            i_sfp_tx_flt,
  output logic            o_SerialData,
  output logic            o_drv_en,
  output logic            o_sfp_tx_dis_n,
  output logic            o_frame_stb,
  output logic [1:0]      o_tx_led
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_MODE   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic [2:0]      state, state_nx;
  logic [7:0]      clk_cnt, clk_nx;
  logic [3:0]      idx, idx_nx;
  logic [7:0]      flt_cnt, flt_nx;
  logic            flt_s1, flt_s2;
  logic            run;
  logic            snap_mode;
  logic [N_CH-1:0] snap_ch;
  logic [7:0]      ch_pad;
  logic            capture, stb_nx, line, bit_end, frame_nx;

  assign ch_pad   = 8'(snap_ch);
  assign bit_end  = (clk_cnt == 8'(CLK_DIV - 1));
  assign frame_nx = (state_nx != S_IDLE) && (state_nx != S_FAULT);

  always_comb begin
    case (state)
      S_SYNC:   line = (idx != 4'd3);
      S_MODE:   line = snap_mode;
      S_DATA:   line = ch_pad[idx[2:0]];
      S_PARITY: line = ^{snap_mode, snap_ch};
      default:  line = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    clk_nx   = clk_cnt;
    idx_nx   = idx;
    flt_nx   = flt_cnt;
    capture  = 1'b0;
    stb_nx   = 1'b0;
    if (flt_s2) begin
      state_nx = S_FAULT;
      clk_nx   = '0;
      idx_nx   = '0;
      flt_nx   = '0;
    end else begin
      case (state)
        S_IDLE: if (i_en && run) begin
          state_nx = S_SYNC;
          capture  = 1'b1;
        end
        S_FAULT: if (flt_cnt == 8'(FLT_CLR - 1)) begin
          state_nx = S_IDLE;
          flt_nx   = '0;
        end else begin
          flt_nx = flt_cnt + 8'd1;
        end
        default: if (!bit_end) begin
          clk_nx = clk_cnt + 8'd1;
        end else begin
          clk_nx = '0;
          idx_nx = idx + 4'd1;
          case (state)
            S_SYNC: if (idx == 4'd3) begin
              state_nx = S_MODE;
              idx_nx   = '0;
            end
            S_MODE: begin
              state_nx = S_DATA;
              idx_nx   = '0;
            end
            S_DATA: if (idx == 4'(N_CH - 1)) begin
              state_nx = S_PARITY;
              idx_nx   = '0;
            end
            S_PARITY: begin
              state_nx = S_GAP;
              idx_nx   = '0;
            end
            S_GAP: if (idx == 4'(IDLE_GAP - 1)) begin
              idx_nx = '0;
              stb_nx = 1'b1;
              if (i_en) begin
                state_nx = S_SYNC;
                capture  = 1'b1;
              end else begin
                state_nx = S_IDLE;
              end
            end
            default: begin
              state_nx = S_IDLE;
              idx_nx   = '0;
            end
          endcase
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they switch on the same edge as the FSM;
  // the line is forced low on the fault edge so an aborted bit never lingers into FAULT.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      flt_s1         <= 1'b0;
      flt_s2         <= 1'b0;
      run            <= 1'b0;
      state          <= S_IDLE;
      clk_cnt        <= '0;
      idx            <= '0;
      flt_cnt        <= '0;
      snap_mode      <= 1'b0;
      snap_ch        <= '0;
      o_SerialData   <= 1'b0;
      o_drv_en       <= 1'b0;
      o_sfp_tx_dis_n <= 1'b0;
      o_frame_stb    <= 1'b0;
      o_tx_led       <= 2'b00;
    end else begin
      flt_s1         <= i_sfp_tx_flt;
      flt_s2         <= flt_s1;
      run            <= 1'b1;
      state          <= state_nx;
      clk_cnt        <= clk_nx;
      idx            <= idx_nx;
      flt_cnt        <= flt_nx;
      if (capture) begin
        snap_mode <= i_IsMaster;
        snap_ch   <= i_ch;
      end
      o_SerialData   <= flt_s2 ? 1'b0 : line;
      o_drv_en       <= frame_nx;
      o_sfp_tx_dis_n <= (state_nx != S_FAULT);
      o_frame_stb    <= stb_nx;
      o_tx_led       <= {state_nx == S_FAULT, frame_nx};
    end
  end

endmodule

// File: tb/tb_drsstc_link_tx_mch.sv
// Directed bench for drsstc_link_tx_mch: frame vector table plus fault, enable-drop,
// reset-abort and back-to-back period sequences.
module tb_drsstc_link_tx_mch;

  localparam int FLT_CLR = 16;

  logic       clk = 1'b0;
  logic       rst_n, en, master, flt;
  logic [3:0] ch;
  logic       ser, drv_en, dis_n, stb;
  logic [1:0] led;

  logic       en8, master8, flt8;
  logic [7:0] ch8;
  logic       ser8, drv_en8, dis_n8, stb8;
  logic [1:0] led8;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  drsstc_link_tx_mch #(.N_CH(4), .CLK_DIV(8), .IDLE_GAP(2), .FLT_CLR(FLT_CLR)) dut (
    .i_clk(clk), .i_res_n(rst_n), .i_en(en), .i_IsMaster(master), .i_ch(ch),
    .i_sfp_tx_flt(flt), .o_SerialData(ser), .o_drv_en(drv_en), .o_sfp_tx_dis_n(dis_n),
    .o_frame_stb(stb), .o_tx_led(led)
  );

  drsstc_link_tx_mch #(.N_CH(8), .CLK_DIV(2), .IDLE_GAP(1), .FLT_CLR(FLT_CLR)) dut8 (
    .i_clk(clk), .i_res_n(rst_n), .i_en(en8), .i_IsMaster(master8), .i_ch(ch8),
    .i_sfp_tx_flt(flt8), .o_SerialData(ser8), .o_drv_en(drv_en8), .o_sfp_tx_dis_n(dis_n8),
    .o_frame_stb(stb8), .o_tx_led(led8)
  );

  typedef struct {
    logic        master;
    logic [3:0]  ch;
    logic [11:0] bits;   // first transmitted bit in [11]
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_sync(input string name);
    int n = 0;
    while (!drv_en && n < 200) begin
      step();
      n++;
    end
    chk({name, " sync entry"}, 32'(drv_en), 32'd1);
  endtask

  // Runs one frame from IDLE; drop_k=0 drops enable right after SYNC entry.
  task automatic run_frame(input logic [11:0] bits, input int drop_k, input bit toggle,
                           input string name);
    int extra;
    en = 1'b1;
    wait_sync(name);
    if (drop_k == 0) en = 1'b0;
    for (int k = 0; k < 96; k++) begin
      step();
      if (toggle && (k % 3 == 0)) begin
        ch     = ~ch;
        master = ~master;
      end
      if (drop_k > 0 && k == drop_k) en = 1'b0;
      chk($sformatf("%s line k%0d", name, k), 32'(ser), 32'(bits[11 - k / 8]));
      chk($sformatf("%s stb k%0d", name, k), 32'(stb), 32'(k == 95));
    end
    step();
    chk({name, " idle after"}, 32'({drv_en, ser, stb, led}), 32'd0);
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (stb || drv_en || ser) extra++;
    end
    chk({name, " stays idle"}, 32'(extra), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    en = 1'b0;
    while (drv_en && n < 200) begin
      step();
      n++;
    end
    step();
    chk("drain to idle", 32'(drv_en), 32'd0);
  endtask

  initial begin
    int n;
    int stb_seen;
    int bad_line, bad_stb, stb_cnt;
    logic [14:0] exp8;

    vecs[0] = '{1'b1, 4'b1010, 12'b1110_1_0101_1_00};
    vecs[1] = '{1'b0, 4'b0000, 12'b1110_0_0000_0_00};
    vecs[2] = '{1'b0, 4'b0001, 12'b1110_0_1000_1_00};
    vecs[3] = '{1'b1, 4'b1111, 12'b1110_1_1111_1_00};
    vecs[4] = '{1'b0, 4'b0110, 12'b1110_0_0110_0_00};
    vecs[5] = '{1'b1, 4'b0111, 12'b1110_1_1110_0_00};

    rst_n = 1'b0; en = 1'b0; master = 1'b0; flt = 1'b0; ch = '0;
    en8 = 1'b0; master8 = 1'b0; flt8 = 1'b0; ch8 = '0;
    repeat (3) step();
    chk("reset outs", 32'({ser, drv_en, dis_n, stb, led}), 32'd0);
    chk("reset outs n8", 32'({ser8, drv_en8, dis_n8, stb8, led8}), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle after release", 32'({ser, drv_en, dis_n, stb, led}), 32'b001000);

    for (int i = 0; i < 6; i++) begin
      master = vecs[i].master;
      ch     = vecs[i].ch;
      run_frame(vecs[i].bits, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Inputs toggling mid-frame must not leak into the snapshot.
    master = 1'b0;
    ch     = 4'b0110;
    run_frame(12'b1110_0_0110_0_00, 0, 1'b1, "toggle");

    // Enable dropped during DATA: frame and gap still complete.
    master = 1'b1;
    ch     = 4'b1010;
    run_frame(12'b1110_1_0101_1_00, 50, 1'b0, "en drop");

    // One-clock fault pulse mid-DATA.
    en = 1'b1;
    wait_sync("fault");
    repeat (45) step();
    stb_seen = 0;
    flt = 1'b1;
    step();
    flt = 1'b0;
    n = 0;
    while (dis_n && n < 3) begin
      step();
      n++;
      if (stb) stb_seen++;
    end
    chk("fault dis_n", 32'(dis_n), 32'd0);
    chk("fault outs", 32'({drv_en, ser, led}), 32'b0010);
    while (!drv_en && n < 60) begin
      step();
      n++;
      if (stb) stb_seen++;
    end
    chk("fault resume window", 32'(n >= FLT_CLR + 1 && n <= FLT_CLR + 3), 32'd1);
    chk("fault no stb", 32'(stb_seen), 32'd0);
    chk("fault resume leds", 32'({dis_n, led}), 32'b101);
    drain();

    // Reset asserted in PARITY.
    en = 1'b1;
    wait_sync("reset");
    repeat (75) step();
    rst_n = 1'b0;
    #1;
    chk("async reset outs", 32'({ser, drv_en, dis_n, stb, led}), 32'd0);
    step();
    chk("held reset outs", 32'({ser, drv_en, dis_n, stb, led}), 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (!ser && n < 20) begin
      step();
      n++;
    end
    chk("first bit after release", 32'(n >= 2 && n < 20), 32'd1);
    drain();

    // Back-to-back frames on the 8-channel instance.
    master8 = 1'b1;
    ch8     = 8'hA5;
    exp8    = 15'b1110_1_10100101_1_0;
    en8     = 1'b1;
    n = 0;
    while (!drv_en8 && n < 200) begin
      step();
      n++;
    end
    chk("n8 sync entry", 32'(drv_en8), 32'd1);
    bad_line = 0;
    bad_stb  = 0;
    stb_cnt  = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (ser8 !== exp8[14 - (k % 30) / 2]) bad_line++;
      if (stb8 !== (k % 30 == 29)) bad_stb++;
      if (stb8) stb_cnt++;
    end
    en8 = 1'b0;
    chk("n8 line errors", 32'(bad_line), 32'd0);
    chk("n8 period errors", 32'(bad_stb), 32'd0);
    chk("n8 frame count", 32'(stb_cnt), 32'd100);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/drsstc_link_tx_mch.md
DRSSTC_LINK_TX_MCH -- requirements
Module: drsstc_link_tx_mch

Interface
REQ-001 Parameter N_CH, default 4, range 1..8: number of pulse/option channels carried per frame.
REQ-002 Parameter CLK_DIV, default 8, range 2..255: clocks per serial bit.
REQ-003 Parameter IDLE_GAP, default 2, range 1..15: low bit periods between frames.
REQ-004 Parameter FLT_CLR, default 16, range 1..255: consecutive fault-free clocks required before leaving FAULT.
REQ-005 i_clk  input  1  sole clock; all logic rising-edge.
REQ-006 i_res_n  input  1  reset, asynchronous, active-low.
REQ-007 i_en  input  1  transmit enable.
REQ-008 i_IsMaster  input  1  mode bit placed in each frame.
REQ-009 i_ch  input  N_CH  channel levels (raw pulse on bit 0, options above).
REQ-010 i_sfp_tx_flt  input  1  SFP transmitter fault, active-high, asynchronous to frame timing.
REQ-011 o_SerialData  output  1  NRZ serial line, registered.
REQ-012 o_drv_en  output  1  LVDS driver enable.
REQ-013 o_sfp_tx_dis_n  output  1  SFP transmit enable (low disables).
REQ-014 o_frame_stb  output  1  one-clock pulse at end of each complete frame.
REQ-015 o_tx_led  output  2  [0] activity, [1] fault.

Function
REQ-016 States SHALL be IDLE, SYNC, MODE, DATA, PARITY, GAP, FAULT.
REQ-017 Frame bit order SHALL be: SYNC 1,1,1,0; MODE = i_IsMaster; DATA i_ch[0] first up to i_ch[N_CH-1]; PARITY = even parity over MODE and DATA bits; then GAP of IDLE_GAP bit periods at 0.
REQ-018 Each bit SHALL hold o_SerialData for exactly CLK_DIV clocks; a frame including gap SHALL last (6+N_CH+IDLE_GAP)*CLK_DIV clocks.
REQ-019 i_IsMaster and i_ch SHALL be captured into a snapshot register on the clock entering SYNC; input changes during a frame SHALL NOT affect that frame.
REQ-020 o_SerialData SHALL present the first SYNC bit on the clock after the SYNC entry edge (one-clock registered latency).
REQ-021 IDLE -> SYNC when i_en=1 and no fault; GAP end -> SYNC if i_en=1, else IDLE.
REQ-022 i_en falling mid-frame SHALL NOT truncate the frame; the frame and its gap SHALL complete.
REQ-023 o_frame_stb SHALL pulse for one clock on the last clock of GAP of every completed frame, never for aborted frames.
REQ-024 o_drv_en SHALL be 1 in SYNC through GAP and 0 in IDLE and FAULT; o_SerialData SHALL be 0 in IDLE and FAULT.
REQ-025 i_sfp_tx_flt SHALL be double-registered; synchronised fault high SHALL force FAULT from any state on the next clock, aborting any frame.
REQ-026 In FAULT: o_sfp_tx_dis_n=0, o_drv_en=0, o_SerialData=0, o_tx_led[1]=1.
REQ-027 FAULT -> IDLE after FLT_CLR consecutive clocks of synchronised fault low; any fault high restarts the count.
REQ-028 o_sfp_tx_dis_n SHALL be 1 in all states other than FAULT after reset release.
REQ-029 o_tx_led[0] SHALL be 1 while state is not IDLE/FAULT; bit and gap counters SHALL be wide enough for the maximum parameters without wrap.

Reset
REQ-030 While i_res_n=0: state IDLE, all counters 0, snapshot 0, o_SerialData=0, o_drv_en=0, o_sfp_tx_dis_n=0, o_frame_stb=0, o_tx_led=2'b00.
REQ-031 Reset assertion mid-frame SHALL abort immediately with outputs at reset values; no o_frame_stb.
REQ-032 After release, IDLE for at least one clock before SYNC; fault synchroniser cleared to 0.

Verification
REQ-033 N_CH=4, CLK_DIV=8, IDLE_GAP=2, i_en=1, i_IsMaster=1, i_ch=4'b1010 -> line 1,1,1,0,1,0,1,0,1,1,0,0 each 8 clocks; o_frame_stb 96 clocks after first SYNC bit start.
REQ-034 i_ch toggled every 3 clocks during a frame -> transmitted DATA equals value at SYNC entry; parity matches.
REQ-035 i_sfp_tx_flt pulsed high 1 clock mid-DATA -> FAULT within 3 clocks, o_sfp_tx_dis_n=0, no o_frame_stb; resumes SYNC FLT_CLR+1..FLT_CLR+3 clocks after fault low.
REQ-036 i_en dropped in DATA -> frame and gap complete, o_frame_stb once, then IDLE with line 0.
REQ-037 i_res_n asserted in PARITY -> all outputs reset values asynchronously; release -> first SYNC bit no earlier than 2 clocks later.
REQ-038 N_CH=8, CLK_DIV=2, IDLE_GAP=1 back-to-back frames -> period 30 clocks, no gap-state skew over 100 frames.
